// File: rtl/ffs_dispatch_16_if.sv
// ffs_dispatch_16_if: request-post and grant-issue signals of the
// find-first-set dispatcher.
//
// Handshake: a grant transfers on every rising edge where issue_valid and
// issue_ready are both high. While issue_valid is high and issue_ready is low,
// issue_idx and issue_onehot hold stable. set_en/set_vec and flush are plain
// strobes with no handshake.
interface ffs_dispatch_16_if;
  logic        set_en;
  logic [15:0] set_vec;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_idx;
  logic [15:0] issue_onehot;
  logic        issue_ready;
  logic [15:0] pending;
  logic        idle;

  // Requester/consumer side (testbench or surrounding logic)
  modport master (
    output set_en, set_vec, flush, issue_ready,
    input  issue_valid, issue_idx, issue_onehot, pending, idle
  );

  // Dispatcher side
  modport slave (
    input  set_en, set_vec, flush, issue_ready,
    output issue_valid, issue_idx, issue_onehot, pending, idle
  );
endinterface

// File: rtl/ffs_dispatch_16.sv
// ffs_dispatch_16: 16-entry find-first-set dispatcher. Requests accumulate in
// a pending register; each cycle the lowest set bit (or, in round-robin mode,
// the lowest set bit above the last grant, wrapping) is loaded into a
// registered valid/ready output stage and cleared from pending.
//
// Optional feature macro: FFS_DISPATCH_RR_EN selects round-robin priority
// (two prefix-OR networks plus a last_idx pointer). Undefined: fixed priority,
// lowest index first, one prefix network.

// Parallel-prefix OR: p[i] = |x[i:0], built as a log2(16)-stage network.
module parPrefix2OR_16 (
  input  logic [15:0] x,
  output logic [15:0] p
);
  logic [15:0] s1, s2, s3;

  // Four doubling stages: spans of 1, 2, 4, 8 bits toward higher indices
  always_comb begin
    s1 = x  | (x  << 1);
    s2 = s1 | (s1 << 2);
    s3 = s2 | (s2 << 4);
    p  = s3 | (s3 << 8);
  end
endmodule

module ffs_dispatch_16 (
  input  logic              clk,
  input  logic              rst,
  ffs_dispatch_16_if.slave  bus
);
  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic [N-1:0]     pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     onehot_q, onehot_d;

  logic [N-1:0]     p_full;
  logic [N-1:0]     sel_p;
  logic [N-1:0]     sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             load;
  logic             take;

  parPrefix2OR_16 u_prefix_full (
    .x (pending_q),
    .p (p_full)
  );

`ifdef FFS_DISPATCH_RR_EN
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [N-1:0]     upper_mask;
  logic [N-1:0]     masked;
  logic [N-1:0]     p_masked;

  // Mask of bits strictly above the last granted index
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (i > int'(last_idx_q));
    end
  end

  assign masked = pending_q & upper_mask;

  parPrefix2OR_16 u_prefix_masked (
    .x (masked),
    .p (p_masked)
  );

  // Prefer requests above the pointer; an empty upper half wraps to bit 0
  assign sel_p = p_masked[N-1] ? p_masked : p_full;
`else
  assign sel_p = p_full;
`endif

  assign sel_onehot = sel_p & ~(sel_p << 1);
  assign sel_any    = sel_p[N-1];
  assign load       = !valid_q | bus.issue_ready;
  assign take       = load & sel_any & !bus.flush;

  // Binary encode of the one-hot selection
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_onehot[i]) sel_idx = sel_idx | IDX_W'(i);
    end
  end

  // Next state: grant load clears its bit, a same-cycle set re-arms it,
  // and flush overrides both
  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    if (load) valid_d = sel_any;
    if (take) begin
      idx_d     = sel_idx;
      onehot_d  = sel_onehot;
      pending_d = pending_q & ~sel_onehot;
    end
    if (bus.set_en) pending_d = pending_d | bus.set_vec;
    if (bus.flush) begin
      pending_d = '0;
      valid_d   = 1'b0;
    end
  end

`ifdef FFS_DISPATCH_RR_EN
  // Pointer follows every grant load; flush leaves it alone
  always_comb begin
    last_idx_d = last_idx_q;
    if (take) last_idx_d = sel_idx;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_idx_q <= IDX_W'(N - 1);
    else     last_idx_q <= last_idx_d;
  end
`endif

  // Pending register and output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
    end
  end

  assign bus.issue_valid  = valid_q;
  assign bus.issue_idx    = idx_q;
  assign bus.issue_onehot = onehot_q;
  assign bus.pending      = pending_q;
  assign bus.idle         = (pending_q == '0) && !valid_q;
endmodule
